// File: rtl/fcl_engine_arbiter.sv
// Round-robin arbiter sharing one FCL engine between NUM_CLIENTS requesters,
// with a start/done handshake and a watchdog that resets a hung engine.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | no job; pick the round-robin winner when any req is high
//   GRANT    | ack pulse to the winner; operand mux starts routing
//   SETUP    | one settle cycle for the operand mux
//   START    | eng_start pulse; watchdog cleared
//   WAIT     | wait for eng_done, watchdog counting
//   COMPLETE | done_o pulse to the client; pointer advances past it
//   ABORT    | eng_rst held for two cycles, then COMPLETE
module fcl_engine_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int CLIENT_W       = $clog2(NUM_CLIENTS),
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CLIENTS-1:0] req,
    output logic [NUM_CLIENTS-1:0] ack,
    output logic [NUM_CLIENTS-1:0] done_o,
    output logic [CLIENT_W-1:0]    sel,
    output logic                   sel_valid,
    output logic                   eng_start,
    input  logic                   eng_done,
    output logic                   eng_rst,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [CLIENT_W-1:0]    err_client,
    input  logic                   clr_err
);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SETUP,
        START,
        WAIT,
        COMPLETE,
        ABORT
    } state_t;

    state_t                   state, state_next;
    logic [CLIENT_W-1:0]      ptr, ptr_next;
    logic [CLIENT_W-1:0]      sel_next;
    logic [CNT_W-1:0]         wd_cnt, wd_cnt_next;
    logic                     ab_cnt, ab_cnt_next;
    logic                     err_set;
    logic [CLIENT_W-1:0]      win;
    logic                     found;
    int                       j;

    logic [NUM_CLIENTS-1:0]   ack_next, done_next;
    logic                     eng_start_next, eng_rst_next, busy_next;

    // First requesting client at or after the pointer, wrapping.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            j = (int'(ptr) + i) % NUM_CLIENTS;
            if (!found && req[CLIENT_W'(j)]) begin
                win   = CLIENT_W'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        sel_next    = sel;
        ptr_next    = ptr;
        wd_cnt_next = wd_cnt;
        ab_cnt_next = ab_cnt;
        err_set     = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_next   = win;
                    state_next = GRANT;
                end
            end
            GRANT: state_next = SETUP;
            SETUP: state_next = START;
            START: begin
                wd_cnt_next = '0;
                state_next  = WAIT;
            end
            WAIT: begin
                // Done has priority over a watchdog expiry on the same edge.
                if (eng_done) begin
                    state_next = COMPLETE;
                end else if ((TIMEOUT_CYCLES != 0) &&
                             (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    state_next  = ABORT;
                    ab_cnt_next = 1'b0;
                    err_set     = 1'b1;
                end else begin
                    wd_cnt_next = wd_cnt + 1'b1;
                end
            end
            COMPLETE: begin
                ptr_next   = CLIENT_W'((int'(sel) + 1) % NUM_CLIENTS);
                state_next = IDLE;
            end
            ABORT: begin
                if (ab_cnt) state_next = COMPLETE;
                else        ab_cnt_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pulse outputs are decoded from the next state and registered.
    always_comb begin
        ack_next       = '0;
        done_next      = '0;
        eng_start_next = (state_next == START);
        eng_rst_next   = (state_next == ABORT);
        busy_next      = (state_next != IDLE);
        if (state_next == GRANT)    ack_next  = NUM_CLIENTS'(1) << sel_next;
        if (state_next == COMPLETE) done_next = NUM_CLIENTS'(1) << sel_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            sel         <= '0;
            wd_cnt      <= '0;
            ab_cnt      <= 1'b0;
            ack         <= '0;
            done_o      <= '0;
            eng_start   <= 1'b0;
            eng_rst     <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            err_client  <= '0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            sel       <= sel_next;
            wd_cnt    <= wd_cnt_next;
            ab_cnt    <= ab_cnt_next;
            ack       <= ack_next;
            done_o    <= done_next;
            eng_start <= eng_start_next;
            eng_rst   <= eng_rst_next;
            busy      <= busy_next;
            if (err_set) begin
                timeout_err <= 1'b1;
                err_client  <= sel;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

    assign sel_valid = busy;

endmodule

// File: tb/tb_fcl_engine_arbiter.sv
// Directed bench for fcl_engine_arbiter: single job, rotation, wrap priority,
// watchdog abort, done-vs-expiry race, spurious done and async reset.
module tb_fcl_engine_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] ack;
    logic [3:0] done_o;
    logic [1:0] sel;
    logic       sel_valid;
    logic       eng_start;
    logic       eng_done;
    logic       eng_rst;
    logic       busy;
    logic       timeout_err;
    logic [1:0] err_client;
    logic       clr_err;

    int tests = 0;
    int fails = 0;
    logic [3:0] rearm = 4'b0000;

    fcl_engine_arbiter #(
        .NUM_CLIENTS   (4),
        .CLIENT_W      (2),
        .TIMEOUT_CYCLES(16),
        .CNT_W         (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ack        (ack),
        .done_o     (done_o),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .eng_rst    (eng_rst),
        .busy       (busy),
        .timeout_err(timeout_err),
        .err_client (err_client),
        .clr_err    (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller is in an IDLE cycle with the winner's req already high.
    task automatic run_job(input int c, input int w);
        logic [3:0] oh;
        oh = 4'b0001 << c;
        step();
        chk("grant_ack", {28'd0, ack}, {28'd0, oh});
        chk("grant_sel", {30'd0, sel}, 32'(c));
        chk("grant_valid", {31'd0, sel_valid}, 32'd1);
        req   = req | rearm;
        rearm = 4'b0000;
        step();
        chk("setup_ack", {28'd0, ack}, 32'd0);
        chk("setup_start", {31'd0, eng_start}, 32'd0);
        step();
        chk("start_pulse", {31'd0, eng_start}, 32'd1);
        repeat (w) step();
        chk("wait_sel_held", {30'd0, sel}, 32'(c));
        chk("wait_no_done", {28'd0, done_o}, 32'd0);
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("done_pulse", {28'd0, done_o}, {28'd0, oh});
        chk("done_no_err", {31'd0, timeout_err}, 32'd0);
        req = req & ~oh;
        step();
        chk("idle_done_clr", {28'd0, done_o}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b0000;
        eng_done = 1'b0;
        clr_err  = 1'b0;
        #12;
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_done", {28'd0, done_o}, 32'd0);
        chk("rst_sel", {30'd0, sel}, 32'd0);
        chk("rst_valid", {31'd0, sel_valid}, 32'd0);
        chk("rst_start", {31'd0, eng_start}, 32'd0);
        chk("rst_eng_rst", {31'd0, eng_rst}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_err_client", {30'd0, err_client}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single request with a 10-cycle engine.
        req = 4'b0001;
        run_job(0, 10);

        // Spurious done while idle.
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("spur_busy", {31'd0, busy}, 32'd0);
        chk("spur_done", {28'd0, done_o}, 32'd0);
        chk("spur_ack", {28'd0, ack}, 32'd0);

        // Fairness from a fresh pointer: 0,1,2,3,0,1.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            run_job(k % 4, 5);
            if (k < 5) rearm = 4'b0001 << (k % 4);
        end

        // Pointer at 2: client 0 wins by wrap, then client 1.
        req = 4'b0011;
        run_job(0, 3);
        chk("prio_req_left", {28'd0, req}, 32'h2);
        run_job(1, 3);

        // Watchdog abort: pointer at 2, client 2 only.
        req = 4'b0100;
        step();
        chk("wd_ack", {28'd0, ack}, 32'h4);
        step();
        step();
        chk("wd_start", {31'd0, eng_start}, 32'd1);
        repeat (16) step();
        chk("wd_last_wait_rst", {31'd0, eng_rst}, 32'd0);
        chk("wd_last_wait_err", {31'd0, timeout_err}, 32'd0);
        step();
        chk("abort1_eng_rst", {31'd0, eng_rst}, 32'd1);
        chk("abort1_err", {31'd0, timeout_err}, 32'd1);
        chk("abort1_err_client", {30'd0, err_client}, 32'd2);
        chk("abort1_done", {28'd0, done_o}, 32'd0);
        chk("abort1_valid", {31'd0, sel_valid}, 32'd1);
        step();
        chk("abort2_eng_rst", {31'd0, eng_rst}, 32'd1);
        step();
        chk("abort_done_rst", {31'd0, eng_rst}, 32'd0);
        chk("abort_done", {28'd0, done_o}, 32'h4);
        chk("abort_done_sel", {30'd0, sel}, 32'd2);
        req = 4'b0000;
        step();
        chk("abort_idle_busy", {31'd0, busy}, 32'd0);
        chk("abort_err_sticky", {31'd0, timeout_err}, 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("clr_err", {31'd0, timeout_err}, 32'd0);
        chk("clr_err_client", {30'd0, err_client}, 32'd2);

        // Done on the exact expiry edge: pointer at 3, client 3.
        req = 4'b1000;
        step();
        chk("race_ack", {28'd0, ack}, 32'h8);
        step();
        step();
        repeat (16) step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("race_done", {28'd0, done_o}, 32'h8);
        chk("race_no_rst", {31'd0, eng_rst}, 32'd0);
        chk("race_no_err", {31'd0, timeout_err}, 32'd0);
        req = 4'b0000;
        step();
        chk("race_idle", {31'd0, busy}, 32'd0);

        // Async reset in WAIT, then the held request is served at once.
        req = 4'b0100;
        step();
        chk("ar_ack", {28'd0, ack}, 32'h4);
        repeat (5) step();
        chk("ar_in_wait", {31'd0, busy}, 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_valid", {31'd0, sel_valid}, 32'd0);
        chk("ar_sel", {30'd0, sel}, 32'd0);
        chk("ar_done", {28'd0, done_o}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("ar_no_done", {28'd0, done_o}, 32'd0);
        step();
        chk("ar_regrant_ack", {28'd0, ack}, 32'h4);
        chk("ar_regrant_sel", {30'd0, sel}, 32'd2);
        step();
        chk("ar_post_ack", {28'd0, ack}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
